uart_cmd_dispatcher: RTL and testbench

//  Shares the stopwatch/watch control inputs between two requesters: the UART RX FIFO (ASCII commands) and the debounced buttons.

---
 rtl/uart_cmd_dispatcher.sv | 104 ++++++++++
 tb/tb_uart_cmd_dispatcher.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_dispatcher.sv
// uart_cmd_dispatcher: turns RX FIFO command bytes and debounced buttons into single-cycle control pulses, echoing acks to TX
module uart_cmd_dispatcher #(
  parameter bit         ECHO_EN     = 1'b1,
  parameter int         TX_WAIT_MAX = 1023,
  parameter logic [7:0] NAK_CHAR    = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty_i,
  input  logic [7:0] rx_data_i,
  output logic       rx_rd_o,
  input  logic       tx_full_i,
  output logic       tx_wr_o,
  output logic [7:0] tx_data_o,
  input  logic       btn_L_i,
  input  logic       btn_R_i,
  output logic       mode_o,
  output logic       sw_run_stop_o,
  output logic       sw_clear_o,
  output logic       sw_stop_o,
  output logic       w_hour_inc_o,
  output logic       w_min_inc_o,
  output logic       ack_drop_o,
  output logic       busy_o
);
  localparam int WW = $clog2(TX_WAIT_MAX + 1);
  typedef enum logic [2:0] {IDLE, POP, LATCH, DECODE, ACK} state_t;
  state_t state_q, state_d;
  logic mode_q, mode_d;
  logic [7:0] cmd_q, cmd_d, ack_q, ack_d;
  logic [WW-1:0] wait_q, wait_d;
  logic btn_r_q, btn_l_q;
  logic is_r, is_l, is_s, is_m, known, fire;
  assign is_r  = cmd_q == 8'h52;
  assign is_l  = cmd_q == 8'h4C;
  assign is_s  = cmd_q == 8'h53;
  assign is_m  = cmd_q == 8'h4D;
  assign known = is_r | is_l | is_s | is_m;
  // A button arriving now or being served now owns the outputs; DECODE waits for it
  assign fire  = (state_q == DECODE) & ~(btn_L_i | btn_R_i | btn_l_q | btn_r_q);
  assign sw_run_stop_o = ~mode_q & (btn_r_q | (fire & is_r));
  assign sw_clear_o    = ~mode_q & (btn_l_q | (fire & is_l));
  assign sw_stop_o     = ~mode_q & fire & is_s;
  assign w_min_inc_o   = mode_q & (btn_r_q | (fire & is_r));
  assign w_hour_inc_o  = mode_q & (btn_l_q | (fire & is_l));
  assign mode_o        = mode_q;
  assign tx_data_o     = ack_q;
  assign busy_o        = state_q != IDLE;
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cmd_d      = cmd_q;
    ack_d      = ack_q;
    wait_d     = '0;
    rx_rd_o    = 1'b0;
    tx_wr_o    = 1'b0;
    ack_drop_o = 1'b0;
    case (state_q)
      IDLE:   state_d = rx_empty_i ? IDLE : POP;
      POP: begin
        rx_rd_o = 1'b1;
        state_d = LATCH;
      end
      LATCH: begin
        cmd_d   = rx_data_i & 8'hDF;
        state_d = DECODE;
      end
      DECODE: if (fire) begin
        mode_d  = mode_q ^ is_m;
        ack_d   = known ? cmd_q : NAK_CHAR;
        state_d = ECHO_EN ? ACK : IDLE;
      end
      ACK: if (!tx_full_i) begin
        tx_wr_o = 1'b1;
        state_d = IDLE;
      end else if (wait_q == WW'(TX_WAIT_MAX - 1)) begin
        ack_drop_o = 1'b1;
        state_d    = IDLE;
      end else begin
        wait_d = wait_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      cmd_q   <= '0;
      ack_q   <= '0;
      wait_q  <= '0;
      btn_r_q <= 1'b0;
      btn_l_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cmd_q   <= cmd_d;
      ack_q   <= ack_d;
      wait_q  <= wait_d;
      btn_r_q <= btn_R_i;
      btn_l_q <= btn_L_i & ~btn_R_i;
    end
  end
endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// tb_uart_cmd_dispatcher: scoreboard bench with FIFO models, directed scenarios and randomized commands/buttons
module tb_uart_cmd_dispatcher;
  logic clk = 1'b0, rst = 1'b1, rx_empty = 1'b1, tx_full = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_rd, tx_wr, mode, run, clr, stp, hour, minc, drop, busy;
  logic [7:0] tx_data;
  int checks = 0, errors = 0;
  byte unsigned rx_q[$];
  int exp_cmd[$];
  int exp_tx[$];
  bit m_mode = 1'b0;
  // command ids: 0 run_stop, 1 clear, 2 stop, 3 hour_inc, 4 min_inc; tx entry 'h100 means dropped ack
  always #5 clk = ~clk;
  uart_cmd_dispatcher #(.ECHO_EN(1'b1), .TX_WAIT_MAX(8), .NAK_CHAR(8'h3F)) dut (
    .clk(clk), .rst(rst), .rx_empty_i(rx_empty), .rx_data_i(rx_data), .rx_rd_o(rx_rd),
    .tx_full_i(tx_full), .tx_wr_o(tx_wr), .tx_data_o(tx_data), .btn_L_i(btn_l), .btn_R_i(btn_r),
    .mode_o(mode), .sw_run_stop_o(run), .sw_clear_o(clr), .sw_stop_o(stp), .w_hour_inc_o(hour),
    .w_min_inc_o(minc), .ack_drop_o(drop), .busy_o(busy));
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask
  always @(posedge clk) begin
    if (rx_rd && rx_q.size() > 0) rx_data <= rx_q.pop_front();
    rx_empty <= rx_q.size() == 0;
  end
  always @(negedge clk) begin
    int n, id;
    logic [31:0] want;
    if (!rst) begin
      n  = $countones({run, clr, stp, hour, minc});
      id = run ? 0 : clr ? 1 : stp ? 2 : hour ? 3 : minc ? 4 : -1;
      if (n != 0) begin
        check("cmd_onehot", n, 1);
        want = exp_cmd.size() > 0 ? exp_cmd.pop_front() : -1;
        check("cmd_pulse", id, want);
      end
      if (tx_wr) begin
        want = exp_tx.size() > 0 ? exp_tx.pop_front() : -1;
        check("tx_byte", {24'h0, tx_data}, want);
      end
      if (drop) begin
        want = exp_tx.size() > 0 ? exp_tx.pop_front() : -1;
        check("ack_drop", 32'h100, want);
      end
    end
  end
  function automatic void model_uart(input logic [7:0] b, input bit dropped);
    logic [7:0] c;
    bit ok;
    c  = b & 8'hDF;
    ok = 1'b1;
    case (c)
      8'h52: exp_cmd.push_back(m_mode ? 4 : 0);
      8'h4C: exp_cmd.push_back(m_mode ? 3 : 1);
      8'h53: if (!m_mode) exp_cmd.push_back(2);
      8'h4D: m_mode = !m_mode;
      default: ok = 1'b0;
    endcase
    exp_tx.push_back(dropped ? 'h100 : ok ? int'(c) : 'h3F);
  endfunction
  task automatic send(input logic [7:0] b);
    model_uart(b, 1'b0);
    rx_q.push_back(b);
  endtask
  task automatic press(input bit l, input bit r);
    if (r) exp_cmd.push_back(m_mode ? 4 : 0);
    else if (l) exp_cmd.push_back(m_mode ? 3 : 1);
    @(posedge clk) #1;
    btn_l = l;
    btn_r = r;
    @(posedge clk) #1;
    btn_l = 1'b0;
    btn_r = 1'b0;
  endtask
  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rx_q.size() == 0 && rx_empty && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0b queued=%0d expected idle", busy, rx_q.size());
    end
  endtask
  task automatic wait_rd();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx_rd) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout: rx_rd=%0b expected 1", rx_rd);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, {rx_rd, tx_wr, drop, busy}, 0);
    check({tag, "_cmds"}, {run, clr, stp, hour, minc}, 0);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_tx_data"}, tx_data, 0);
  endtask
  initial begin
    int te, tr, k;
    byte unsigned tbl[8];
    tbl = '{8'h52, 8'h4C, 8'h53, 8'h4D, 8'h72, 8'h6C, 8'h73, 8'h6D};
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk) #1 rst = 1'b0;
    // 1: latency of a single 'R' in stopwatch mode
    send(8'h52);
    te = -1;
    tr = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!rx_empty && te < 0) te = i;
      if (rx_rd) begin
        tr = i;
        break;
      end
    end
    check("t1_rd_latency", tr - te, 1);
    repeat (2) @(negedge clk);
    check("t1_pulse_n3", run, 1);
    @(negedge clk);
    check("t1_tx_n4", {tx_wr, tx_data}, {1'b1, 8'h52});
    wait_idle();
    // 2/3: lowercase mode switch, watch hour, unknown byte
    send(8'h6D);
    send(8'h6C);
    wait_idle();
    check("t2_mode", mode, 1);
    send(8'h58);
    wait_idle();
    // 4: ack dropped after 8 full cycles, next byte still served
    @(posedge clk) #1 tx_full = 1'b1;
    model_uart(8'h53, 1'b1);
    rx_q.push_back(8'h53);
    send(8'h4C);
    wait_rd();
    k = 0;
    while (!drop && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t4_drop_latency", k, 10);
    @(posedge clk) #1 tx_full = 1'b0;
    wait_idle();
    // 5: button in the DECODE cycle wins, UART command follows a cycle later
    send(8'h4D);
    wait_idle();
    check("t5_mode0", mode, 0);
    exp_cmd.push_back(0);
    exp_cmd.push_back(1);
    exp_tx.push_back(8'h4C);
    rx_q.push_back(8'h4C);
    wait_rd();
    @(posedge clk);
    @(posedge clk) #1 btn_r = 1'b1;
    @(negedge clk);
    check("t5_hold", {run, clr}, 2'b00);
    @(posedge clk) #1 btn_r = 1'b0;
    @(negedge clk);
    check("t5_btn_first", {run, clr}, 2'b10);
    @(negedge clk);
    check("t5_uart_next", {run, clr}, 2'b01);
    wait_idle();
    // 6: reset during LATCH loses the byte, then 's' decodes normally
    send(8'h6D);
    wait_idle();
    rx_q.push_back(8'h52);
    wait_rd();
    @(posedge clk) #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6");
    m_mode = 1'b0;
    @(posedge clk) #1 rst = 1'b0;
    send(8'h73);
    wait_idle();
    // randomized commands, bursts and buttons
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          bit l, r;
          l = 1'($urandom_range(0, 1));
          r = 1'($urandom_range(0, 1));
          if (!l && !r) r = 1'b1;
          press(l, r);
          repeat (2) @(posedge clk);
        end
        1: begin
          for (int j = 0; j < 3; j++) send(tbl[$urandom_range(0, 7)]);
          wait_idle();
        end
        default: begin
          send($urandom_range(0, 1) ? tbl[$urandom_range(0, 7)] : 8'($urandom_range(0, 255)));
          wait_idle();
        end
      endcase
    end
    repeat (5) @(negedge clk);
    check("cmd_queue_drained", exp_cmd.size(), 0);
    check("tx_queue_drained", exp_tx.size(), 0);
    check("mode_final", mode, m_mode);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
